// File: rtl/jk_cmd_if.sv
// Command handshake between a JK stimulus source and the jk_cmd_sequencer.
// One transfer happens on each rising edge where valid and ready are both high.
interface jk_cmd_if;
  logic       valid;
  logic       ready;
  logic [1:0] op;
  logic [3:0] rpt;

  modport master (output valid, output op, output rpt, input ready);
  modport slave  (input valid, input op, input rpt, output ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Queues JK operations, drives J/K to a downstream JK flip-flop, and checks
// the fed-back Q against an internal reference model.
//
// state | meaning
// IDLE  | J=K=0; pop the FIFO head when one is present
// APPLY | drive J/K from op_r for rep_cnt+1 cycles, advancing q_exp
// CHECK | J=K=0; compare q_fb with q_exp, update the counters
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_cmd_if.slave          cmd,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

  state_t      state;
  logic [5:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [5:0]  head;
  logic        full, empty, push, pop;
  logic [1:0]  op_r;
  logic [3:0]  rep_cnt;
  logic        q_exp;

  // The extra MSB on each pointer separates the full case from the empty case.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd.ready = !full;
  assign push      = cmd.valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd.op, cmd.rpt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_r     <= 2'b00;
      rep_cnt  <= 4'd0;
      q_exp    <= 1'b0;
      j        <= 1'b0;
      k        <= 1'b0;
      done_cnt <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            op_r    <= head[5:4];
            rep_cnt <= head[3:0];
            j       <= head[5];
            k       <= head[4];
            state   <= APPLY;
          end
        end
        APPLY: begin
          case (op_r)
            2'b01:   q_exp <= 1'b0;
            2'b10:   q_exp <= 1'b1;
            2'b11:   q_exp <= ~q_exp;
            default: q_exp <= q_exp;
          endcase
          if (rep_cnt == 4'd0) begin
            j     <= 1'b0;
            k     <= 1'b0;
            state <= CHECK;
          end else begin
            rep_cnt <= rep_cnt - 4'd1;
          end
        end
        CHECK: begin
          if (done_cnt != '1) done_cnt <= done_cnt + 1'b1;
          if (q_fb != q_exp) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            err_flag <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          j     <= 1'b0;
          k     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench: jk_cmd_sequencer driving a behavioural JK flip-flop model.
module tb_jk_cmd_sequencer;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             j, k, q_fb, busy, err_flag;
  logic [7:0]       done_cnt, err_cnt;
  logic             q;
  logic             ovr_en = 1'b0;
  int               n_assert = 0;
  int               n_fail = 0;
  int               waits;
  int               base;
  int               mon_len = 0;
  logic [1:0]       mon_jk = 2'b00;
  int               bursts[$];
  int               exp_bursts[5] = '{34, 17, 51, 33, 49};

  jk_cmd_if cmd_if ();

  jk_cmd_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if.slave), .j(j), .k(k), .q_fb(q_fb),
    .busy(busy), .done_cnt(done_cnt), .err_cnt(err_cnt), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  // Downstream JK flip-flop, sharing the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else case ({j, k})
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end
  assign q_fb = ovr_en ? 1'b0 : q;

  // Log each non-zero J/K burst as {jk, length}.
  always @(negedge clk) begin
    if ({j, k} != 2'b00) begin
      mon_jk = {j, k};
      mon_len++;
    end else if (mon_len != 0) begin
      bursts.push_back(int'(mon_jk) * 16 + mon_len);
      mon_len = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present a command, wait (bounded) for ready, then complete the push edge.
  task automatic push(input logic [1:0] op, input logic [3:0] rpt, output int nwait);
    nwait = 0;
    cmd_if.valid = 1'b1;
    cmd_if.op    = op;
    cmd_if.rpt   = rpt;
    while (!cmd_if.ready && nwait < 100) begin
      tick();
      nwait++;
    end
    if (nwait >= 100) chk("push_timeout", 32'(nwait), 32'd0);
    tick();
    cmd_if.valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    cmd_if.valid = 1'b1;
    cmd_if.op    = 2'b10;
    cmd_if.rpt   = 4'd0;

    // 1: reset with a command presented
    repeat (3) tick();
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_ready", 32'(cmd_if.ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    cmd_if.valid = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_j", 32'(j), 32'd0);

    // 2: set, REPEAT=0
    push(2'b10, 4'd0, waits);
    chk("t2_pop_cycle_j", 32'(j), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    tick();
    chk("t2_apply_jk", 32'({j, k}), 32'b10);
    tick();
    chk("t2_check_jk", 32'({j, k}), 32'b00);
    chk("t2_check_q", 32'(q_fb), 32'd1);
    tick();
    chk("t2_done", 32'(done_cnt), 32'd1);
    chk("t2_err", 32'(err_cnt), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);

    // 3: toggle, REPEAT=2 from Q=1
    push(2'b11, 4'd2, waits);
    tick();
    chk("t3_jk1", 32'({j, k}), 32'b11);
    chk("t3_q1", 32'(q), 32'd1);
    tick();
    chk("t3_jk2", 32'({j, k}), 32'b11);
    chk("t3_q2", 32'(q), 32'd0);
    tick();
    chk("t3_jk3", 32'({j, k}), 32'b11);
    chk("t3_q3", 32'(q), 32'd1);
    tick();
    chk("t3_check_jk", 32'({j, k}), 32'b00);
    chk("t3_check_q", 32'(q), 32'd0);
    tick();
    chk("t3_done", 32'(done_cnt), 32'd2);
    chk("t3_err", 32'(err_cnt), 32'd0);

    // 4: long hold then five more back-to-back, from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    base = bursts.size();
    push(2'b00, 4'd15, waits);
    push(2'b10, 4'd1, waits);
    push(2'b01, 4'd0, waits);
    push(2'b11, 4'd2, waits);
    push(2'b10, 4'd0, waits);
    chk("t4_full_ready", 32'(cmd_if.ready), 32'd0);
    push(2'b11, 4'd0, waits);
    chk("t4_stall_cycles", 32'(waits), 32'd15);
    wait_idle("t4_busy_drop");
    tick();
    chk("t4_done", 32'(done_cnt), 32'd6);
    chk("t4_err", 32'(err_cnt), 32'd0);
    chk("t4_burst_count", 32'(bursts.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < bursts.size())
        chk($sformatf("t4_burst%0d", i), 32'(bursts[base + i]), 32'(exp_bursts[i]));
    end

    // 5: forced mismatch, then a clean command
    ovr_en = 1'b1;
    push(2'b10, 4'd0, waits);
    repeat (3) tick();
    chk("t5_err_cnt", 32'(err_cnt), 32'd1);
    chk("t5_err_flag", 32'(err_flag), 32'd1);
    ovr_en = 1'b0;
    push(2'b01, 4'd0, waits);
    repeat (3) tick();
    chk("t5_err_hold", 32'(err_cnt), 32'd1);
    chk("t5_flag_hold", 32'(err_flag), 32'd1);
    chk("t5_done", 32'(done_cnt), 32'd8);

    // 6: reset during the 4th APPLY cycle of a long toggle
    push(2'b11, 4'd10, waits);
    repeat (4) tick();
    chk("t6_apply4_jk", 32'({j, k}), 32'b11);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_jk", 32'({j, k}), 32'b00);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done_cnt), 32'd0);
    chk("t6_flag", 32'(err_flag), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    push(2'b11, 4'd0, waits);
    repeat (3) tick();
    chk("t6_after_done", 32'(done_cnt), 32'd1);
    chk("t6_after_err", 32'(err_cnt), 32'd0);
    chk("t6_after_q", 32'(q), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
